// File: rtl/regfile_mp_sb.sv
// Multi-read, dual-write register file with a per-register pending scoreboard.
// Write port 0 is the writeback path; port 1 returns long-latency results and retires their pending bits.
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr0_en,
    input  logic [ADDR_W-1:0]          wr0_addr,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic                       wr1_en,
    input  logic [ADDR_W-1:0]          wr1_addr,
    input  logic [DATA_W-1:0]          wr1_data,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    input  logic                       flush,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    output logic [(2**ADDR_W)-1:0]     pend_vec
);

    localparam int   DEPTH = 2**ADDR_W;
    localparam logic ZR    = (ZERO_REG != 0);
    localparam logic BYP   = (BYPASS != 0);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [ADDR_W-1:0] rd_idx [NUM_RD];

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_idx
        assign rd_idx[k] = rd_addr[k*ADDR_W +: ADDR_W];
    end

    // Array next state: wr0 wins over wr1 when both target the same register.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (ZR && i == 0) begin
                mem_d[i] = {DATA_W{1'b0}};
            end else if (wr0_en && wr0_addr == ADDR_W'(i)) begin
                mem_d[i] = wr0_data;
            end else if (wr1_en && wr1_addr == ADDR_W'(i)) begin
                mem_d[i] = wr1_data;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Scoreboard next state: an issue in the same cycle as a return keeps the bit set.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (ZR && i == 0) begin
                pend_d[i] = 1'b0;
            end else if (flush) begin
                pend_d[i] = 1'b0;
            end else if (iss_en && iss_addr == ADDR_W'(i)) begin
                pend_d[i] = 1'b1;
            end else if (wr1_en && wr1_addr == ADDR_W'(i)) begin
                pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = pend_q[i];
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            pend_q <= {DEPTH{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            pend_q <= pend_d;
        end
    end

    assign pend_vec = pend_q;

    // Read ports: a returning wr1 value is forwarded, so that port need not stall.
    always_comb begin
        rd_data = {(NUM_RD*DATA_W){1'b0}};
        rd_busy = {NUM_RD{1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            if (ZR && rd_idx[k] == {ADDR_W{1'b0}}) begin
                rd_data[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                rd_busy[k]                  = 1'b0;
            end else begin
                if (BYP && wr0_en && wr0_addr == rd_idx[k]) begin
                    rd_data[k*DATA_W +: DATA_W] = wr0_data;
                end else if (BYP && wr1_en && wr1_addr == rd_idx[k]) begin
                    rd_data[k*DATA_W +: DATA_W] = wr1_data;
                end else begin
                    rd_data[k*DATA_W +: DATA_W] = mem_q[rd_idx[k]];
                end
                rd_busy[k] = pend_q[rd_idx[k]] &&
                             !(BYP && wr1_en && wr1_addr == rd_idx[k]);
            end
        end
    end

endmodule
